// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback scheduler.
// No logic; sizes and requester identifiers only.
// Requester IDs double as bit positions in the arbiter valid/grant vectors.
package regfile_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;

  // Requester identifiers; also the value held by the last_grant flag
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-way round-robin arbiter between ALU and load writeback requests.
// Latency: combinational, zero cycles.
// Backpressure: the loser of a tie sees no grant and must hold its request.
module wb_rr_arb
  import regfile_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Single requester always wins; on a tie the one not served last wins
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant[0] = 1'b1;
      2'b10:   grant[1] = 1'b1;
      2'b11: begin
        if (last_grant == REQ_MEM) grant[REQ_ALU] = 1'b1;
        else                       grant[REQ_MEM] = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU/load results onto one register-file write port
// and keeps a per-register pending-write scoreboard for issue hazard detection.
// Latency: 1 cycle from handshake to wb_en; ready is combinational, loser is stalled.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dst,
  input  logic [BIT_WIDTH-1:0]  alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [BIT_WIDTH-1:0]  mem_data,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic [BIT_WIDTH-1:0]  wb_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  idle
);

  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic                  last_grant;
  logic                  handshake;
  logic [REG_ADDR_W-1:0] win_dst;
  logic [BIT_WIDTH-1:0]  win_data;
  logic                  issue_acc;
  logic [NUM_REGS-1:0]   busy_nxt;

  assign req_valid[REQ_ALU] = alu_valid;
  assign req_valid[REQ_MEM] = mem_valid;

  wb_rr_arb u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];
  assign handshake = |grant;

  // Select the winning requester's destination and data
  always_comb begin
    win_dst  = alu_dst;
    win_data = alu_data;
    if (grant[REQ_MEM]) begin
      win_dst  = mem_dst;
      win_data = mem_data;
    end
  end

  // Register the winner; writes to r0 are consumed but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en      <= 1'b0;
      wb_dst     <= '0;
      wb_data    <= '0;
      last_grant <= REQ_MEM;
    end else begin
      wb_en <= handshake && (win_dst != '0);
      if (handshake) begin
        wb_dst     <= win_dst;
        wb_data    <= win_data;
        last_grant <= grant[REQ_MEM] ? REQ_MEM : REQ_ALU;
      end
    end
  end

  // Both RAW (sources) and WAW (destination) against pending writes stall issue
  assign hazard    = busy[src1] | busy[src2] | busy[issue_dst];
  assign issue_acc = issue_valid && !hazard;

  // Clear on the actual register-file write, then set on accepted issue so a
  // same-edge set/clear of one register leaves it pending
  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_dst] = 1'b0;
    if (issue_acc && (issue_dst != '0)) busy_nxt[issue_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign idle = ~(|busy) & ~wb_en;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a writeback scoreboard.
// Stimulus pushes the expected (dst, data) of each enabled write; a monitor pops on wb_en.
// Inputs change on negedge; outputs are sampled 1 ns after negedge or 2 ns after posedge.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [3:0]  alu_dst, mem_dst, wb_dst, issue_dst, src1, src2;
  logic [31:0] alu_data, mem_data, wb_data;
  logic        wb_en, issue_valid, hazard, idle;
  logic [15:0] busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];

  regfile_wb_sched #(.BIT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .src1(src1), .src2(src2),
    .hazard(hazard), .busy(busy), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every enabled write must match the oldest expected entry
  initial begin
    logic [35:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {wb_dst, wb_data}, 36'h0);
          if ({wb_dst, wb_data} == 36'h0) begin
            n_err++;
            $display("FAIL unexpected_write: got wb_en=1, expected no write");
          end
        end else begin
          e = exp_q.pop_front();
          check("wb_dst_data", {wb_dst, wb_data}, e);
        end
      end
    end
  end

  // Drive one cycle at negedge, check combinational outputs, advance to next negedge
  task automatic step(input string tag,
                      input logic av, input logic [3:0] ad, input logic [31:0] adat,
                      input logic mv, input logic [3:0] md, input logic [31:0] mdat,
                      input logic iv, input logic [3:0] idst, input logic [3:0] s1,
                      input logic [3:0] s2,
                      input logic exp_ar, input logic exp_mr, input logic exp_hz);
    alu_valid = av; alu_dst = ad; alu_data = adat;
    mem_valid = mv; mem_dst = md; mem_data = mdat;
    issue_valid = iv; issue_dst = idst; src1 = s1; src2 = s2;
    #1;
    check({tag, "_alu_ready"}, {35'h0, alu_ready}, {35'h0, exp_ar});
    check({tag, "_mem_ready"}, {35'h0, mem_ready}, {35'h0, exp_mr});
    check({tag, "_hazard"},    {35'h0, hazard},    {35'h0, exp_hz});
    if (exp_ar && ad != 4'd0) exp_q.push_back({ad, adat});
    if (exp_mr && md != 4'd0) exp_q.push_back({md, mdat});
    @(negedge clk);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_dst = 0; alu_data = 0;
    mem_valid = 0; mem_dst = 0; mem_data = 0;
    issue_valid = 0; issue_dst = 0; src1 = 0; src2 = 0;
    @(negedge clk); @(negedge clk);

    // Reset state and ready behaviour while held in reset
    check("rst_busy",  {20'h0, busy},    36'h0);
    check("rst_wb_en", {35'h0, wb_en},   36'h0);
    check("rst_wb",    {wb_dst, wb_data}, 36'h0);
    check("rst_idle",  {35'h0, idle},    36'h1);
    alu_valid = 1; mem_valid = 1; #1;
    check("rst_tie_ready", {34'h0, alu_ready, mem_ready}, 36'h2);
    alu_valid = 0; #1;
    check("rst_mem_ready", {34'h0, alu_ready, mem_ready}, 36'h1);
    mem_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin under continuous contention: ALU, MEM, ALU, MEM
    step("rr0", 1, 4'd1, 32'hA000_0000, 1, 4'd2, 32'hB000_0000, 0, 0, 0, 0, 1, 0, 0);
    step("rr1", 1, 4'd1, 32'hA000_0001, 1, 4'd2, 32'hB000_0001, 0, 0, 0, 0, 0, 1, 0);
    step("rr2", 1, 4'd1, 32'hA000_0002, 1, 4'd2, 32'hB000_0002, 0, 0, 0, 0, 1, 0, 0);
    step("rr3", 1, 4'd1, 32'hA000_0003, 1, 4'd2, 32'hB000_0003, 0, 0, 0, 0, 0, 1, 0);
    idle_step("rr_drain");
    check("rr_busy_unchanged", {20'h0, busy}, 36'h0);

    // Scoreboard set, RAW/WAW hazards, clear one cycle after the write
    step("iss5", 0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd0, 4'd0, 0, 0, 0);
    check("busy_after_iss5", {20'h0, busy}, 36'h0020);
    step("raw5", 0, 0, 0, 0, 0, 0, 1, 4'd6, 4'd5, 4'd0, 0, 0, 1);
    step("raw5b", 0, 0, 0, 0, 0, 0, 1, 4'd6, 4'd0, 4'd5, 0, 0, 1);
    step("waw5", 0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd0, 4'd0, 0, 0, 1);
    check("busy_stalled", {20'h0, busy}, 36'h0020);
    step("wb5", 1, 4'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("wb5_en", {35'h0, wb_en}, 36'h1);
    check("busy_during_wb5", {20'h0, busy}, 36'h0020);
    idle_step("wb5_done");
    check("busy_after_wb5", {20'h0, busy}, 36'h0);

    // Write to r0: consumed, no enable, scoreboard untouched
    step("r0", 0, 0, 0, 1, 4'd0, 32'h0000_1234, 0, 0, 0, 0, 0, 1, 0);
    check("r0_wb_en", {35'h0, wb_en}, 36'h0);
    check("r0_busy", {20'h0, busy}, 36'h0);
    check("r0_idle", {35'h0, idle}, 36'h1);

    // Issue to r7 on the edge that writes r7: set wins
    step("w7", 1, 4'd7, 32'h7777_0001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("iss7_on_wb7", 0, 0, 0, 0, 0, 0, 1, 4'd7, 4'd0, 4'd0, 0, 0, 0);
    check("busy7_set_wins", {20'h0, busy}, 36'h0080);
    step("w7b", 1, 4'd7, 32'h7777_0002, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_step("w7b_done");
    check("busy7_cleared", {20'h0, busy}, 36'h0);

    // Last grant was ALU, and idle cycles do not move it: tie goes to MEM, then ALU
    idle_step("gap");
    step("tie_m", 1, 4'd8, 32'h8888_0000, 1, 4'd9, 32'h9999_0000, 0, 0, 0, 0, 0, 1, 0);
    idle_step("gap2");
    step("tie_a", 1, 4'd8, 32'h8888_0001, 1, 4'd9, 32'h9999_0001, 0, 0, 0, 0, 1, 0, 0);
    idle_step("tie_drain");

    // Build busy=0x00F0 with a write in flight, then reset asynchronously
    step("iss4", 0, 0, 0, 0, 0, 0, 1, 4'd4, 4'd0, 4'd0, 0, 0, 0);
    step("iss5b", 0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd0, 4'd0, 0, 0, 0);
    step("iss6", 0, 0, 0, 0, 0, 0, 1, 4'd6, 4'd0, 4'd0, 0, 0, 0);
    step("iss7", 1, 4'd1, 32'hCAFE_F00D, 0, 0, 0, 1, 4'd7, 4'd0, 4'd0, 1, 0, 0);
    check("pre_rst_busy", {20'h0, busy}, 36'h00F0);
    check("pre_rst_wb_en", {35'h0, wb_en}, 36'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {20'h0, busy},  36'h0);
    check("arst_wb_en", {35'h0, wb_en}, 36'h0);
    check("arst_idle",  {35'h0, idle},  36'h1);
    check("arst_wb",    {wb_dst, wb_data}, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step("post_rst0");
    idle_step("post_rst1");
    check("post_rst_idle", {35'h0, idle}, 36'h1);

    // Tie right after reset goes to ALU again
    step("post_rst_tie", 1, 4'd3, 32'h3333_3333, 1, 4'd10, 32'hAAAA_AAAA, 0, 0, 0, 0, 1, 0, 0);
    idle_step("final_drain");
    idle_step("final_drain2");
    check("scoreboard_empty", {4'h0, 32'(exp_q.size())}, 36'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter: BIT_WIDTH, 32, writeback data width.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: alu_valid  in  1  ALU writeback request.
REQ-005 SHALL have port: alu_ready  out  1  ALU request accepted this cycle.
REQ-006 SHALL have port: alu_dst  in  4  ALU destination register.
REQ-007 SHALL have port: alu_data  in  BIT_WIDTH  ALU result.
REQ-008 SHALL have port: mem_valid  in  1  load writeback request.
REQ-009 SHALL have port: mem_ready  out  1  load request accepted this cycle.
REQ-010 SHALL have port: mem_dst  in  4  load destination register.
REQ-011 SHALL have port: mem_data  in  BIT_WIDTH  load result.
REQ-012 SHALL have port: wb_en  out  1  register-file write enable (registered).
REQ-013 SHALL have port: wb_dst  out  4  register-file write address (registered).
REQ-014 SHALL have port: wb_data  out  BIT_WIDTH  register-file write data (registered).
REQ-015 SHALL have port: issue_valid  in  1  instruction issue claiming issue_dst.
REQ-016 SHALL have port: issue_dst, src1, src2  in  4 each  issuing instruction's destination and sources.
REQ-017 SHALL have port: hazard  out  1  issuing instruction must stall.
REQ-018 SHALL have port: busy  out  16  per-register pending-write bits.
REQ-019 SHALL have port: idle  out  1  no busy bit set and wb_en low.

Function
REQ-020 Handshake per requester SHALL be valid && ready; ready SHALL be combinational and high only for the granted requester; at most one ready high per cycle.
REQ-021 Only one valid: that requester SHALL be granted; both valid: the requester not granted most recently SHALL win (round-robin via last_grant flag).
REQ-022 last_grant SHALL update only on a handshake.
REQ-023 On handshake at edge N, wb_dst/wb_data SHALL load the winner's dst/data; wb_en SHALL be high during cycle N..N+1 (latency 1) iff dst != 0.
REQ-024 A handshake with dst == 0 SHALL be consumed (ready high) but produce wb_en = 0.
REQ-025 With no handshake, wb_en SHALL be 0 next cycle; wb_dst/wb_data SHALL hold.
REQ-026 hazard SHALL be combinational: busy[src1] | busy[src2] | busy[issue_dst] (RAW and WAW).
REQ-027 Issue is accepted iff issue_valid && !hazard; if accepted and issue_dst != 0, busy[issue_dst] SHALL set at the next edge.
REQ-028 busy[wb_dst] SHALL clear at the edge ending a cycle with wb_en high (i.e. when the register file actually writes), not at handshake.
REQ-029 Same-edge set and clear of the same register: set SHALL win.
REQ-030 busy[0] SHALL be constant 0.
REQ-031 Requesters SHALL be unconstrained against busy; a writeback to a non-busy register SHALL still write and leave busy unchanged.

Reset
REQ-032 rst_n low SHALL immediately force: busy = 0, wb_en = 0, wb_dst = 0, wb_data = 0, last_grant = MEM (so ALU wins first tie); idle = 1; ready outputs follow valids.
REQ-033 Reset mid-operation SHALL discard registered writeback and all pending busy bits; no write SHALL issue after rst_n rises until a new handshake.

Structure
REQ-034 Package regfile_pkg SHALL hold NUM_REGS = 16, REG_ADDR_W = 4, and requester-ID constants REQ_ALU = 0, REQ_MEM = 1.
REQ-035 Two-way round-robin grant logic SHALL be the sub-module wb_rr_arb (valid[1:0], last_grant in; grant[1:0] out); scoreboard and writeback registers SHALL stay in the top.

Verification
REQ-036 After reset, alu_valid=1 and mem_valid=1 held for 4 cycles -> grants ALU, MEM, ALU, MEM; wb_en high each following cycle.
REQ-037 issue_valid=1, issue_dst=5 -> busy=0x0020 next cycle; issue with src1=5 -> hazard=1; ALU handshake dst=5 data=0xDEADBEEF -> wb_en=1, wb_dst=5 next cycle, busy[5]=0 the cycle after.
REQ-038 mem_valid=1, mem_dst=0, mem_data=0x1234 -> mem_ready=1, wb_en stays 0, busy unchanged.
REQ-039 Issue to reg 7 on the same edge wb_en writes reg 7 -> busy[7] remains 1.
REQ-040 busy=0x00F0 and wb_en=1, assert rst_n=0 mid-cycle -> busy=0, wb_en=0, idle=1 without a clock edge.
